id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Pipeline register between instruction decode (register-file read) and execute.
- Captures register-file read data RD1/RD2, the sign-extended immediate, PC+4, register specifiers and decoded control bits on each rising clock edge.
- Contains the load-use hazard detector. It raises a stall toward PC/IF-ID and inserts a bubble into EX.
- Accepts a flush from branch resolution.

Parameters:
- DW, 32, data path width (RD1, RD2, immediate, PC+4).
- CNT_W, 16, width of the saturating stall-event counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs, id_rt, id_rd  in  5 each  register specifiers from the instruction.
- id_uses_rs, id_uses_rt  in  1 each  instruction actually reads rs / rt.
- id_rd1, id_rd2  in  DW each  register-file read data (RD1, RD2).
- id_imm  in  DW  sign-extended immediate.
- id_pc4  in  DW  PC+4.
- id_ctrl  in  10  {RegWrite, MemtoReg, MemRead, MemWrite, Branch, ALUSrc, RegDst, ALUOp[1:0], Jump}, MSB first.
- flush  in  1  branch/jump taken in EX; kill the instruction currently in ID.
- stall  out  1  combinational; hold PC and IF/ID this cycle.
- ex_valid  out  1  EX stage holds a real instruction.
- ex_rs, ex_rt, ex_rd  out  5 each  registered specifiers.
- ex_rd1, ex_rd2, ex_imm, ex_pc4  out  DW each  registered data.
- ex_ctrl  out  10  registered control, same field order as id_ctrl.
- ex_mem_read  out  1  alias of ex_ctrl[7] (MemRead).
- stall_cnt  out  CNT_W  number of stall cycles since reset, saturating.

Behaviour:
- Reset: a rising edge with rst_n=0 clears all ex_* outputs and stall_cnt to 0, and sets ex_valid=0. stall is 0 while ex_valid=0.
- Hazard term: load_use = ex_valid & ex_mem_read & (ex_rt != 0) & ((id_uses_rs & id_rs == ex_rt) | (id_uses_rt & id_rt == ex_rt)).
- Stall output: stall = id_valid & load_use & ~flush. It is purely combinational with no added latency.
- Update priority at each rising edge, highest first: reset, flush, stall, normal.
  - flush=1: ex_valid<=0 and ex_ctrl<=0. Data and specifier fields load normally; they are don't-care downstream.
  - stall=1 (bubble): ex_valid<=0 and ex_ctrl<=0. Data and specifier fields hold their previous values.
  - Normal: all fields capture their id_* inputs. ex_valid<=id_valid. ex_ctrl<=id_valid ? id_ctrl : 0.
- Stall length: a stall lasts exactly one cycle. The inserted bubble clears ex_mem_read, so stall deasserts on the next cycle. The held ID instruction then advances with fresh RD1/RD2 from the register file.
- Register 0: $0 as a load destination never causes a stall.
- No false stalls: an rs/rt match is ignored when the corresponding id_uses_* is 0. Example: a load whose rt is its own destination does not stall on rt.
- Flush vs stall: simultaneous flush and hazard produces flush behaviour with stall=0.
- Invalid ID slot: id_valid=0 never stalls and loads a bubble.
- Latency: ID inputs appear on ex_* one cycle later.
- stall_cnt: increments by 1 on every rising edge where stall=1. It saturates at 2^CNT_W-1 and does not wrap.
- Reset mid-stall: reset wins, ex_valid=0, and stall drops the same cycle.
- Register-file interaction: the register file writes on the falling edge. A write-back in the same cycle is therefore visible on id_rd1/id_rd2 before the rising edge, and this block needs no WB bypass.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with random inputs -> all ex_* = 0, ex_valid=0, stall=0, stall_cnt=0.
- Pass-through: id_valid=1, id_rs=3, id_rt=4, id_rd=5, id_rd1=0x11111111, id_rd2=0x22222222, id_imm=0xFFFFFFF0, id_pc4=0x104, id_ctrl=0x2C1 -> the next edge shows identical ex_* values, ex_valid=1, stall=0.
- Load-use: EX holds lw ($8 <- mem, ex_ctrl MemRead=1, ex_rt=8); ID holds add with id_rs=8, id_uses_rs=1 -> stall=1 for exactly one cycle and the next edge gives ex_valid=0, ex_ctrl=0. The following edge captures the add with ex_valid=1, and stall_cnt=1.
- No false stall: the same lw as above with ID id_rt=8 and id_uses_rt=0, or with ex_rt=0 and id_rs=0 -> stall=0 throughout and the ID instruction passes normally.
- Flush priority: the load-use condition is present and flush=1 on the same cycle -> stall=0, next ex_valid=0, ex_ctrl=0, stall_cnt unchanged.
- Saturation: CNT_W=2; force 5 consecutive load-use hazards -> stall_cnt sequence 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// branch flush and a saturating count of stall cycles.
module id_ex_stage #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [DW-1:0]     id_rd1,
  input  logic [DW-1:0]     id_rd2,
  input  logic [DW-1:0]     id_imm,
  input  logic [DW-1:0]     id_pc4,
  input  logic [9:0]        id_ctrl,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [DW-1:0]     ex_rd1,
  output logic [DW-1:0]     ex_rd2,
  output logic [DW-1:0]     ex_imm,
  output logic [DW-1:0]     ex_pc4,
  output logic [9:0]        ex_ctrl,
  output logic              ex_mem_read,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int MEM_READ_BIT = 7;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic              ex_valid_q, ex_valid_d;
  logic [4:0]        ex_rs_q, ex_rs_d;
  logic [4:0]        ex_rt_q, ex_rt_d;
  logic [4:0]        ex_rd_q, ex_rd_d;
  logic [DW-1:0]     ex_rd1_q, ex_rd1_d;
  logic [DW-1:0]     ex_rd2_q, ex_rd2_d;
  logic [DW-1:0]     ex_imm_q, ex_imm_d;
  logic [DW-1:0]     ex_pc4_q, ex_pc4_d;
  logic [9:0]        ex_ctrl_q, ex_ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic rs_hit, rt_hit, load_use;

  // Hazard detection against the load currently sitting in EX
  always_comb begin
    rs_hit   = id_uses_rs & (id_rs == ex_rt_q);
    rt_hit   = id_uses_rt & (id_rt == ex_rt_q);
    load_use = ex_valid_q & ex_ctrl_q[MEM_READ_BIT] & (ex_rt_q != 5'd0)
               & (rs_hit | rt_hit);
    // Gating with rst_n lets a reset release PC/IF-ID in the same cycle.
    stall    = rst_n & id_valid & load_use & ~flush;
  end

  always_comb begin
    ex_valid_d  = id_valid;
    ex_ctrl_d   = id_valid ? id_ctrl : 10'd0;
    ex_rs_d     = id_rs;
    ex_rt_d     = id_rt;
    ex_rd_d     = id_rd;
    ex_rd1_d    = id_rd1;
    ex_rd2_d    = id_rd2;
    ex_imm_d    = id_imm;
    ex_pc4_d    = id_pc4;
    stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
    if (flush) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = 10'd0;
    end else if (stall) begin
      // Bubble: kill control, keep the old payload so EX sees stable values
      ex_valid_d = 1'b0;
      ex_ctrl_d  = 10'd0;
      ex_rs_d    = ex_rs_q;
      ex_rt_d    = ex_rt_q;
      ex_rd_d    = ex_rd_q;
      ex_rd1_d   = ex_rd1_q;
      ex_rd2_d   = ex_rd2_q;
      ex_imm_d   = ex_imm_q;
      ex_pc4_d   = ex_pc4_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_rd_q     <= '0;
      ex_rd1_q    <= '0;
      ex_rd2_q    <= '0;
      ex_imm_q    <= '0;
      ex_pc4_q    <= '0;
      ex_ctrl_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      ex_rd_q     <= ex_rd_d;
      ex_rd1_q    <= ex_rd1_d;
      ex_rd2_q    <= ex_rd2_d;
      ex_imm_q    <= ex_imm_d;
      ex_pc4_q    <= ex_pc4_d;
      ex_ctrl_q   <= ex_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_rs       = ex_rs_q;
  assign ex_rt       = ex_rt_q;
  assign ex_rd       = ex_rd_q;
  assign ex_rd1      = ex_rd1_q;
  assign ex_rd2      = ex_rd2_q;
  assign ex_imm      = ex_imm_q;
  assign ex_pc4      = ex_pc4_q;
  assign ex_ctrl     = ex_ctrl_q;
  assign ex_mem_read = ex_ctrl_q[MEM_READ_BIT];
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model pushes the expected EX
// contents each cycle, popped and compared one edge later.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam logic [9:0] CTRL_LW  = 10'h390;
  localparam logic [9:0] CTRL_ADD = 10'h20C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic id_valid = 1'b0, id_uses_rs = 1'b0, id_uses_rt = 1'b0, flush = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic [DW-1:0] id_rd1 = '0, id_rd2 = '0, id_imm = '0, id_pc4 = '0;
  logic [9:0] id_ctrl = '0;

  logic stall, ex_valid, ex_mem_read;
  logic [4:0] ex_rs, ex_rt, ex_rd;
  logic [DW-1:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
  logic [9:0] ex_ctrl;
  logic [15:0] stall_cnt;

  logic s_stall, s_ex_valid, s_ex_mem_read;
  logic [4:0] s_ex_rs, s_ex_rt, s_ex_rd;
  logic [DW-1:0] s_ex_rd1, s_ex_rd2, s_ex_imm, s_ex_pc4;
  logic [9:0] s_ex_ctrl;
  logic [1:0] s_stall_cnt;

  id_ex_stage #(.DW(DW), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc4(id_pc4),
    .id_ctrl(id_ctrl), .flush(flush), .stall(stall), .ex_valid(ex_valid),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
    .ex_ctrl(ex_ctrl), .ex_mem_read(ex_mem_read), .stall_cnt(stall_cnt)
  );

  id_ex_stage #(.DW(DW), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc4(id_pc4),
    .id_ctrl(id_ctrl), .flush(flush), .stall(s_stall), .ex_valid(s_ex_valid),
    .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_rd(s_ex_rd),
    .ex_rd1(s_ex_rd1), .ex_rd2(s_ex_rd2), .ex_imm(s_ex_imm), .ex_pc4(s_ex_pc4),
    .ex_ctrl(s_ex_ctrl), .ex_mem_read(s_ex_mem_read), .stall_cnt(s_stall_cnt)
  );

  typedef struct packed {
    logic          v;
    logic [4:0]    rs, rt, rd;
    logic [DW-1:0] rd1, rd2, imm, pc4;
    logic [9:0]    ctrl;
    logic [15:0]   cnt;
    logic [1:0]    cnts;
  } exp_t;

  exp_t q[$];
  exp_t m = '0;
  int n_tests = 0;
  int n_fail  = 0;
  logic last_stall = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: check combinational stall, predict next EX state, compare after edge
  task automatic step();
    exp_t e;
    exp_t got;
    logic hz, s_exp;
    #1;
    hz = m.v & m.ctrl[7] & (m.rt != 5'd0) &
         ((id_uses_rs && id_rs == m.rt) || (id_uses_rt && id_rt == m.rt));
    s_exp = rst_n & id_valid & hz & ~flush;
    last_stall = s_exp;
    check_val("stall", {63'd0, stall}, {63'd0, s_exp});
    check_val("stall_sat", {63'd0, s_stall}, {63'd0, s_exp});
    e = m;
    if (!rst_n) begin
      e = '0;
    end else if (flush) begin
      e.v = 1'b0; e.ctrl = '0;
      e.rs = id_rs; e.rt = id_rt; e.rd = id_rd;
      e.rd1 = id_rd1; e.rd2 = id_rd2; e.imm = id_imm; e.pc4 = id_pc4;
    end else if (s_exp) begin
      e.v = 1'b0; e.ctrl = '0;
    end else begin
      e.v = id_valid; e.ctrl = id_valid ? id_ctrl : 10'd0;
      e.rs = id_rs; e.rt = id_rt; e.rd = id_rd;
      e.rd1 = id_rd1; e.rd2 = id_rd2; e.imm = id_imm; e.pc4 = id_pc4;
    end
    if (rst_n && s_exp) begin
      if (m.cnt != 16'hFFFF) e.cnt = m.cnt + 16'd1;
      if (m.cnts != 2'd3) e.cnts = m.cnts + 2'd1;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      check_val("queue_empty", 64'd1, 64'd0);
    end else begin
      got = q.pop_front();
      check_val("ex_valid", {63'd0, ex_valid}, {63'd0, got.v});
      check_val("ex_rs", {59'd0, ex_rs}, {59'd0, got.rs});
      check_val("ex_rt", {59'd0, ex_rt}, {59'd0, got.rt});
      check_val("ex_rd", {59'd0, ex_rd}, {59'd0, got.rd});
      check_val("ex_rd1", {32'd0, ex_rd1}, {32'd0, got.rd1});
      check_val("ex_rd2", {32'd0, ex_rd2}, {32'd0, got.rd2});
      check_val("ex_imm", {32'd0, ex_imm}, {32'd0, got.imm});
      check_val("ex_pc4", {32'd0, ex_pc4}, {32'd0, got.pc4});
      check_val("ex_ctrl", {54'd0, ex_ctrl}, {54'd0, got.ctrl});
      check_val("ex_mem_read", {63'd0, ex_mem_read}, {63'd0, got.ctrl[7]});
      check_val("stall_cnt", {48'd0, stall_cnt}, {48'd0, got.cnt});
      check_val("stall_cnt_sat", {62'd0, s_stall_cnt}, {62'd0, got.cnts});
      check_val("ex_valid_sat", {63'd0, s_ex_valid}, {63'd0, got.v});
      m = got;
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic urs, input logic urt,
                       input logic [9:0] ctrl, input logic fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_uses_rs = urs; id_uses_rt = urt; id_ctrl = ctrl; flush = fl;
    id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom; id_pc4 = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] sat_seq [5];
    sat_seq[0] = 2'd1; sat_seq[1] = 2'd2; sat_seq[2] = 2'd3;
    sat_seq[3] = 2'd3; sat_seq[4] = 2'd3;
    @(posedge clk); #1;

    // Reset with random inputs for two edges
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 10'($urandom), 1'b0);
      step();
    end
    rst_n = 1'b1;

    // Pass-through
    drive(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 10'h2C1, 1'b0);
    id_rd1 = 32'h11111111; id_rd2 = 32'h22222222; id_imm = 32'hFFFFFFF0; id_pc4 = 32'h104;
    step();
    check_val("pass_rd1", {32'd0, ex_rd1}, 64'h11111111);
    check_val("pass_ctrl", {54'd0, ex_ctrl}, 64'h2C1);

    // Load-use: lw $8, then add using $8 as rs
    drive(1'b1, 5'd1, 5'd8, 5'd8, 1'b1, 1'b0, CTRL_LW, 1'b0); step();
    drive(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b1, CTRL_ADD, 1'b0); step();
    check_val("lu_bubble_valid", {63'd0, ex_valid}, 64'd0);
    id_rd1 = $urandom; step();
    check_val("lu_add_valid", {63'd0, ex_valid}, 64'd1);
    check_val("lu_cnt", {48'd0, stall_cnt}, 64'd1);

    // No false stall: rt match with uses_rt=0, and $0 destination
    drive(1'b1, 5'd1, 5'd8, 5'd8, 1'b1, 1'b0, CTRL_LW, 1'b0); step();
    drive(1'b1, 5'd2, 5'd8, 5'd11, 1'b1, 1'b0, CTRL_LW, 1'b0); step();
    drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, CTRL_LW, 1'b0); step();
    drive(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b1, CTRL_ADD, 1'b0); step();
    check_val("nofalse_cnt", {48'd0, stall_cnt}, 64'd1);

    // Flush beats a simultaneous hazard
    drive(1'b1, 5'd1, 5'd8, 5'd8, 1'b1, 1'b0, CTRL_LW, 1'b0); step();
    drive(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b1, CTRL_ADD, 1'b1); step();
    check_val("flush_valid", {63'd0, ex_valid}, 64'd0);
    check_val("flush_cnt", {48'd0, stall_cnt}, 64'd1);

    // Invalid ID slot never stalls
    drive(1'b1, 5'd1, 5'd8, 5'd8, 1'b1, 1'b0, CTRL_LW, 1'b0); step();
    drive(1'b0, 5'd8, 5'd8, 5'd10, 1'b1, 1'b1, CTRL_ADD, 1'b0); step();

    // Reset during a hazard: stall drops, EX cleared
    drive(1'b1, 5'd1, 5'd8, 5'd8, 1'b1, 1'b0, CTRL_LW, 1'b0); step();
    drive(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b1, CTRL_ADD, 1'b0);
    rst_n = 1'b0; step();
    rst_n = 1'b1;

    // Saturation: chain of dependent loads, five stalls
    drive(1'b1, 5'd1, 5'd8, 5'd8, 1'b1, 1'b0, CTRL_LW, 1'b0); step();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0, CTRL_LW, 1'b0); step();
      check_val("sat_seq", {62'd0, s_stall_cnt}, {62'd0, sat_seq[k]});
      step();
    end

    // Random traffic over a small register set to hit hazards often
    for (int i = 0; i < 300; i++) begin
      if (last_stall) begin
        id_rd1 = $urandom; id_rd2 = $urandom;
        flush = ($urandom_range(0, 9) == 0);
      end else begin
        drive(($urandom_range(0, 5) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 1) == 1) ? CTRL_LW : 10'($urandom),
              ($urandom_range(0, 9) == 0));
      end
      rst_n = ($urandom_range(0, 49) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
